// File: rtl/or1200_fwd_ctrl.sv
// Operand-forwarding and load-use interlock controller for or1200_operandmuxes.
// Optional perf counters (fwd_cnt, stall_cnt) are built when OR1200_FWD_PERF_EN is defined.
module or1200_fwd_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_freeze,
    input  logic       ex_freeze,
    input  logic       if_valid,
    input  logic [4:0] if_rfa_addr,
    input  logic       if_rfa_en,
    input  logic [4:0] if_rfb_addr,
    input  logic       if_rfb_en,
    input  logic       if_imm_b,
    input  logic [4:0] if_rfd_addr,
    input  logic       if_rfwb,
    input  logic       if_load,
    output logic [1:0] sel_a,
    output logic [1:0] sel_b,
    output logic       hz_stall
`ifdef OR1200_FWD_PERF_EN
    ,
    output logic [15:0] fwd_cnt,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        SEL_RF  = 2'b00,
        SEL_IMM = 2'b01,
        SEL_EXF = 2'b10,
        SEL_WBF = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        MODE_ADV,
        MODE_DRAIN,
        MODE_HOLD
    } mode_e;

    logic [4:0] id_rfd;
    logic       id_wb;
    logic       id_ld;
    logic [4:0] ex_rfd;
    logic       ex_wb;

    mode_e mode;
    sel_e  adv_sel_a;
    sel_e  adv_sel_b;
    logic  a_id, a_ex, b_id, b_ex;
    logic  adv_stall;

    function automatic logic src_match(input logic en, input logic [4:0] addr,
                                       input logic wb, input logic [4:0] rfd);
        return en && (addr != 5'd0) && wb && (addr == rfd);
    endfunction

    // A code one stage older: EX-forward becomes WB-forward, WB-forward falls back to the RF.
    function automatic logic [1:0] age_sel(input logic [1:0] s);
        case (s)
            SEL_EXF: return SEL_WBF;
            SEL_WBF: return SEL_RF;
            default: return s;
        endcase
    endfunction

    always_comb begin
        mode = MODE_ADV;
        if (ex_freeze)
            mode = MODE_HOLD;
        else if (id_freeze)
            mode = MODE_DRAIN;
    end

    always_comb begin
        a_id = src_match(if_rfa_en, if_rfa_addr, id_wb, id_rfd);
        a_ex = src_match(if_rfa_en, if_rfa_addr, ex_wb, ex_rfd);
        b_id = src_match(if_rfb_en, if_rfb_addr, id_wb, id_rfd);
        b_ex = src_match(if_rfb_en, if_rfb_addr, ex_wb, ex_rfd);

        adv_sel_a = SEL_RF;
        if (if_valid) begin
            if (a_id)
                adv_sel_a = SEL_EXF;
            else if (a_ex)
                adv_sel_a = SEL_WBF;
        end

        adv_sel_b = SEL_RF;
        if (if_imm_b)
            adv_sel_b = SEL_IMM;
        else if (if_valid) begin
            if (b_id)
                adv_sel_b = SEL_EXF;
            else if (b_ex)
                adv_sel_b = SEL_WBF;
        end

        adv_stall = id_ld && ((adv_sel_a == SEL_EXF) || (adv_sel_b == SEL_EXF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_rfd   <= '0;
            id_wb    <= 1'b0;
            id_ld    <= 1'b0;
            ex_rfd   <= '0;
            ex_wb    <= 1'b0;
            sel_a    <= SEL_RF;
            sel_b    <= SEL_RF;
            hz_stall <= 1'b0;
        end else begin
            case (mode)
                MODE_ADV: begin
                    id_rfd   <= if_rfd_addr;
                    id_wb    <= if_rfwb & if_valid;
                    id_ld    <= if_load & if_valid;
                    ex_rfd   <= id_rfd;
                    ex_wb    <= id_wb;
                    sel_a    <= adv_sel_a;
                    sel_b    <= adv_sel_b;
                    hz_stall <= adv_stall;
                end
                MODE_DRAIN: begin
                    ex_wb    <= 1'b0;
                    sel_a    <= age_sel(sel_a);
                    sel_b    <= age_sel(sel_b);
                    hz_stall <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef OR1200_FWD_PERF_EN
    logic adv_fwd;

    assign adv_fwd = adv_sel_a[1] | adv_sel_b[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((mode == MODE_ADV) && adv_fwd && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + 16'd1;
            if (hz_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_or1200_fwd_ctrl.sv
// Scoreboard bench for or1200_fwd_ctrl: expected sel/stall codes are queued at drive time
// and compared after the clock edge; counter checks run when OR1200_FWD_PERF_EN is defined.
module tb_or1200_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       id_freeze = 1'b0;
    logic       ex_freeze = 1'b0;
    logic       if_valid = 1'b0;
    logic [4:0] if_rfa_addr = '0;
    logic       if_rfa_en = 1'b0;
    logic [4:0] if_rfb_addr = '0;
    logic       if_rfb_en = 1'b0;
    logic       if_imm_b = 1'b0;
    logic [4:0] if_rfd_addr = '0;
    logic       if_rfwb = 1'b0;
    logic       if_load = 1'b0;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       hz_stall;
`ifdef OR1200_FWD_PERF_EN
    logic [15:0] fwd_cnt;
    logic [15:0] stall_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic       hz;
    } exp_t;

    exp_t sb[$];

    or1200_fwd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .id_freeze  (id_freeze),
        .ex_freeze  (ex_freeze),
        .if_valid   (if_valid),
        .if_rfa_addr(if_rfa_addr),
        .if_rfa_en  (if_rfa_en),
        .if_rfb_addr(if_rfb_addr),
        .if_rfb_en  (if_rfb_en),
        .if_imm_b   (if_imm_b),
        .if_rfd_addr(if_rfd_addr),
        .if_rfwb    (if_rfwb),
        .if_load    (if_load),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .hz_stall   (hz_stall)
`ifdef OR1200_FWD_PERF_EN
        ,
        .fwd_cnt    (fwd_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Push expectation, clock once, pop and compare against the registered outputs.
    task automatic cycle(input string tag, input logic [1:0] ea, input logic [1:0] eb,
                         input logic eh);
        exp_t e;
        sb.push_back('{tag, ea, eb, eh});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".sel_a"}, {30'd0, sel_a}, {30'd0, e.a});
        chk({e.tag, ".sel_b"}, {30'd0, sel_b}, {30'd0, e.b});
        chk({e.tag, ".hz"}, {31'd0, hz_stall}, {31'd0, e.hz});
    endtask

    task automatic adv(input string tag, input logic v,
                       input logic [4:0] ra, input logic ae,
                       input logic [4:0] rb, input logic be, input logic imm,
                       input logic [4:0] rd, input logic wb, input logic ld,
                       input logic [1:0] ea, input logic [1:0] eb, input logic eh);
        @(negedge clk);
        rst = 1'b0; id_freeze = 1'b0; ex_freeze = 1'b0;
        if_valid = v; if_rfa_addr = ra; if_rfa_en = ae; if_rfb_addr = rb; if_rfb_en = be;
        if_imm_b = imm; if_rfd_addr = rd; if_rfwb = wb; if_load = ld;
        cycle(tag, ea, eb, eh);
    endtask

    task automatic frz(input string tag, input logic exf,
                       input logic [1:0] ea, input logic [1:0] eb, input logic eh);
        @(negedge clk);
        rst = 1'b0; id_freeze = 1'b1; ex_freeze = exf;
        cycle(tag, ea, eb, eh);
    endtask

    task automatic do_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1;
            {id_freeze, ex_freeze} = 2'($urandom_range(0, 1)) & 2'b01 ? 2'b11 : 2'b00;
            if_valid = 1'($urandom); if_rfa_addr = 5'($urandom); if_rfa_en = 1'($urandom);
            if_rfb_addr = 5'($urandom); if_rfb_en = 1'($urandom); if_imm_b = 1'($urandom);
            if_rfd_addr = 5'($urandom); if_rfwb = 1'($urandom); if_load = 1'($urandom);
            cycle(tag, 2'b00, 2'b00, 1'b0);
        end
`ifdef OR1200_FWD_PERF_EN
        chk({tag, ".fwd_cnt"}, {16'd0, fwd_cnt}, 32'd0);
        chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
`endif
    endtask

    initial begin
        do_reset("reset");

        // tag,        v  ra  ae  rb  be  imm rd  wb  ld   ea     eb     hz
        adv("w_r3",    1, 0,  0,  0,  0,  0,  3,  1,  0,  2'b00, 2'b00, 0);
        adv("exfwd",   1, 3,  1,  3,  1,  0,  10, 0,  0,  2'b10, 2'b10, 0);
        adv("w_r3b",   1, 0,  0,  0,  0,  0,  3,  1,  0,  2'b00, 2'b00, 0);
        adv("unrel",   1, 0,  0,  0,  0,  0,  9,  1,  0,  2'b00, 2'b00, 0);
        adv("wbfwd",   1, 3,  1,  3,  1,  0,  10, 0,  0,  2'b11, 2'b11, 0);

        adv("w_r5a",   1, 0,  0,  0,  0,  0,  5,  1,  0,  2'b00, 2'b00, 0);
        adv("w_r5b",   1, 0,  0,  0,  0,  0,  5,  1,  0,  2'b00, 2'b00, 0);
        adv("prio",    1, 5,  1,  5,  1,  0,  0,  0,  0,  2'b10, 2'b10, 0);

        adv("w_r0a",   1, 0,  0,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 0);
        adv("w_r0b",   1, 0,  0,  0,  0,  0,  0,  1,  0,  2'b00, 2'b00, 0);
        adv("r0",      1, 0,  1,  0,  1,  0,  0,  0,  0,  2'b00, 2'b00, 0);

        adv("w_r4",    1, 0,  0,  0,  0,  0,  4,  1,  0,  2'b00, 2'b00, 0);
        adv("imm",     1, 4,  1,  4,  1,  1,  0,  0,  0,  2'b10, 2'b01, 0);

        adv("w_r6",    1, 0,  0,  0,  0,  0,  6,  1,  0,  2'b00, 2'b00, 0);
        adv("bub_src", 0, 6,  1,  6,  1,  1,  8,  1,  1,  2'b00, 2'b01, 0);
        adv("bub_dst", 1, 8,  1,  8,  1,  0,  0,  0,  0,  2'b00, 2'b00, 0);

        adv("ld_r7",   1, 0,  0,  0,  0,  0,  7,  1,  1,  2'b00, 2'b00, 0);
        adv("lduse",   1, 7,  1,  0,  0,  0,  0,  0,  0,  2'b10, 2'b00, 1);
        frz("ld_drain", 0, 2'b11, 2'b00, 0);

        adv("ld_r7b",  1, 0,  0,  0,  0,  0,  7,  1,  1,  2'b00, 2'b00, 0);
        adv("lduse_b", 1, 7,  1,  0,  0,  0,  0,  0,  0,  2'b10, 2'b00, 1);
        for (int i = 0; i < 3; i++)
            frz("hold", 1, 2'b10, 2'b00, 1);
        frz("age1", 0, 2'b11, 2'b00, 0);
        frz("age2", 0, 2'b00, 2'b00, 0);

        adv("ld_r7c",  1, 0,  0,  0,  0,  0,  7,  1,  1,  2'b00, 2'b00, 0);
        adv("lduse_c", 1, 7,  1,  7,  1,  0,  0,  0,  0,  2'b10, 2'b10, 1);
        @(negedge clk);
        rst = 1'b1; id_freeze = 1'b1; ex_freeze = 1'b1;
        cycle("rst_mid", 2'b00, 2'b00, 0);
        adv("post_rst", 1, 7,  1,  7,  1,  0,  0,  0,  0,  2'b00, 2'b00, 0);

`ifdef OR1200_FWD_PERF_EN
        do_reset("perf_rst");
        adv("p_w3",    1, 0,  0,  0,  0,  0,  3,  1,  0,  2'b00, 2'b00, 0);
        adv("p_f1",    1, 3,  1,  0,  0,  0,  0,  0,  0,  2'b10, 2'b00, 0);
        adv("p_f2",    1, 0,  0,  3,  1,  0,  0,  0,  0,  2'b00, 2'b11, 0);
        adv("p_ld7",   1, 0,  0,  0,  0,  0,  7,  1,  1,  2'b00, 2'b00, 0);
        adv("p_f3",    1, 7,  1,  0,  0,  0,  0,  0,  0,  2'b10, 2'b00, 1);
        frz("p_drain", 0, 2'b11, 2'b00, 0);
        chk("perf.fwd_cnt", {16'd0, fwd_cnt}, 32'd3);
        chk("perf.stall_cnt", {16'd0, stall_cnt}, 32'd1);

        adv("p_ld7b",  1, 0,  0,  0,  0,  0,  7,  1,  1,  2'b00, 2'b00, 0);
        adv("p_lu",    1, 7,  1,  0,  0,  0,  0,  0,  0,  2'b10, 2'b00, 1);
        @(negedge clk);
        id_freeze = 1'b1; ex_freeze = 1'b1;
        for (int i = 0; i < 70000; i++)
            @(posedge clk);
        #1;
        chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        chk("sat.fwd_cnt", {16'd0, fwd_cnt}, 32'd4);
        chk("sat.hz", {31'd0, hz_stall}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
